lsu_mem_ctrl: RTL and testbench

- Load/store initiator between the core's execute stage and data_memory.
- data_memory offers only a combinational word read and a full-word synchronous write.
- This block sequences LB/LH/LW/LBU/LHU/SB/SH/SW accesses, performs read-modify-write for sub-word stores, and sign/zero-extends load data.
- The core sees a valid/ready request channel and a valid/ready response channel.

---
 rtl/lsu_mem_ctrl_pkg.sv | 26 ++
 rtl/lsu_lane_align.sv | 63 ++++++
 rtl/lsu_mem_ctrl.sv | 177 +++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and constants for the load/store memory controller.
// Holds the data width, RV32I load/store funct3 codes and the controller state encoding.
package lsu_mem_ctrl_pkg;

    localparam int unsigned DATA_WIDTH = 32;

    // Load codes; SB/SH/SW reuse F3_LB/F3_LH/F3_LW.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        MERGE,
        RESP
    } lsu_state_e;

    // Unsigned variants only exist for loads.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/half lane steering: extracts and extends load data, and merges sub-word store
// data into a full memory word.
module lsu_lane_align
    import lsu_mem_ctrl_pkg::*;
(
    input  logic [2:0]            funct3,
    input  logic [1:0]            offset,
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] load_data_c,
    output logic [DATA_WIDTH-1:0] merge_data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Load lane selection and extension.
    always_comb begin
        byte_sel    = word[7:0];
        half_sel    = offset[1] ? word[31:16] : word[15:0];
        load_data_c = '0;
        case (offset)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        case (funct3)
            F3_LB:   load_data_c = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            F3_LH:   load_data_c = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            F3_LW:   load_data_c = word;
            F3_LBU:  load_data_c = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            F3_LHU:  load_data_c = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: load_data_c = '0;
        endcase
    end

    // Store merge: replace only the addressed lane of the current memory word.
    always_comb begin
        merge_data_c = wdata;
        case (funct3)
            F3_LB: begin
                merge_data_c = word;
                case (offset)
                    2'd0:    merge_data_c[7:0]   = wdata[7:0];
                    2'd1:    merge_data_c[15:8]  = wdata[7:0];
                    2'd2:    merge_data_c[23:16] = wdata[7:0];
                    default: merge_data_c[31:24] = wdata[7:0];
                endcase
            end
            F3_LH: begin
                merge_data_c = word;
                if (offset[1]) begin
                    merge_data_c[31:16] = wdata[15:0];
                end else begin
                    merge_data_c[15:0] = wdata[15:0];
                end
            end
            default: merge_data_c = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between execute and a combinational-read, sync-write data memory.
// Optional LSU_MISALIGN_TRAP_EN rejects misaligned H/W accesses instead of aligning them down.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter  int unsigned MEM_SIZE   = 1024,
    localparam int unsigned MEM_ADDR_W = $clog2(MEM_SIZE)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_err_o,
    output logic                  mem_we_o,
    output logic [MEM_ADDR_W-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    lsu_state_e state_q, state_d;

    logic                  we_q;
    logic [2:0]            funct3_q;
    logic [1:0]            offset_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  err_q;

    logic                  req_ready_d;
    logic                  resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_d;
    logic                  resp_err_d;
    logic                  mem_we_d;
    logic [MEM_ADDR_W-1:0] mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_d;

    logic                  capture_c;
    logic                  misalign_c;
    logic                  reject_c;
    logic [DATA_WIDTH-1:0] load_data_c;
    logic [DATA_WIDTH-1:0] merge_data_c;

    // Upper address bits beyond the memory are ignored so accesses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr_i[DATA_WIDTH-1:MEM_ADDR_W];

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_c = ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00))
                     || ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]);
`else
    assign misalign_c = 1'b0;
`endif

    assign reject_c = f3_illegal(req_we_i, req_funct3_i) || misalign_c;

    lsu_lane_align u_lane_align (
        .funct3       (funct3_q),
        .offset       (offset_q),
        .word         (mem_rdata_i),
        .wdata        (wdata_q),
        .load_data_c  (load_data_c),
        .merge_data_c (merge_data_c)
    );

    // State and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            req_ready_o  <= 1'b1;
            resp_valid_o <= 1'b0;
            resp_rdata_o <= '0;
            resp_err_o   <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_o  <= req_ready_d;
            resp_valid_o <= resp_valid_d;
            resp_rdata_o <= resp_rdata_d;
            resp_err_o   <= resp_err_d;
            mem_we_o     <= mem_we_d;
            mem_addr_o   <= mem_addr_d;
            mem_wdata_o  <= mem_wdata_d;
        end
    end

    // Request capture on acceptance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q     <= 1'b0;
            funct3_q <= '0;
            offset_q <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
        end else if (capture_c) begin
            we_q     <= req_we_i;
            funct3_q <= req_funct3_i;
            offset_q <= req_addr_i[1:0];
            wdata_q  <= req_wdata_i;
            err_q    <= reject_c;
        end
    end

    // Rejected requests still pass through ACCESS (without touching memory) so every
    // single-access response, including errors, arrives with the same latency.
    always_comb begin
        state_d      = state_q;
        resp_valid_d = resp_valid_o;
        resp_rdata_d = resp_rdata_o;
        resp_err_d   = resp_err_o;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_o;
        mem_wdata_d  = mem_wdata_o;
        capture_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    capture_c = 1'b1;
                    state_d   = ACCESS;
                    if (!reject_c) begin
                        mem_addr_d = {req_addr_i[MEM_ADDR_W-1:2], 2'b00};
                        if (req_we_i && (req_funct3_i == F3_LW)) begin
                            mem_we_d    = 1'b1;
                            mem_wdata_d = req_wdata_i;
                        end
                    end
                end
            end
            ACCESS: begin
                if (err_q) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = '0;
                end else if (!we_q) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = load_data_c;
                end else if (funct3_q == F3_LW) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = '0;
                end else begin
                    state_d     = MERGE;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = merge_data_c;
                end
            end
            MERGE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = '0;
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl with a behavioural data_memory attached.
module tb_lsu_mem_ctrl;

    localparam int unsigned MEM_SIZE   = 1024;
    localparam int unsigned MEM_ADDR_W = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.MEM_SIZE(MEM_SIZE)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_funct3_i (req_funct3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata)
    );

    // data_memory: combinational read, synchronous word write, plus a bench preload port.
    logic [31:0] mem [0:255];
    logic        pre_we;
    logic [7:0]  pre_idx;
    logic [31:0] pre_data;

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
        else if (pre_we) mem[pre_idx] <= pre_data;
    end

    int cyc = 0;
    int we_cnt = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mem_we) we_cnt <= we_cnt + 1;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          accept;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive one request (called just after a negedge); returns after acceptance.
    task automatic issue(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rdata, input logic exp_err, input int lat);
        exp_t e;
        bit   ok = 1'b0;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        for (int i = 0; i < 50; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: actual=timeout required=req_ready", name);
            req_valid = 1'b0;
            return;
        end
        e.name   = name;
        e.rdata  = exp_rdata;
        e.err    = exp_err;
        e.lat    = lat;
        e.accept = cyc + 1;
        @(negedge clk);
        req_valid = 1'b0;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: actual=%0d pending required=0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        pre_idx  = idx;
        pre_data = data;
        pre_we   = 1'b1;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    // Monitor: compares each response handshake against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (resp_valid && resp_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: actual=%h required=none", resp_rdata);
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, "_rdata"}, resp_rdata, e.rdata);
                    check({e.name, "_err"}, 32'(resp_err), 32'(e.err));
                    check({e.name, "_latency"}, 32'(cyc + 1 - e.accept), 32'(e.lat));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int w0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        pre_we     = 1'b0;
        pre_idx    = '0;
        pre_data   = '0;
        repeat (2) @(negedge clk);

        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        w0 = we_cnt;
        issue("sw", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        drain();
        check("mem_after_sw", mem[4], 32'hDEADBEEF);
        check("we_pulses_sw", 32'(we_cnt - w0), 32'd1);

        w0 = we_cnt;
        issue("lw", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);
        issue("lw_wrap", 1'b0, 3'b010, 32'h410, 32'h0, 32'hDEADBEEF, 1'b0, 2);
        drain();
        check("we_pulses_lw", 32'(we_cnt - w0), 32'd0);

        preload(8'd8, 32'h11223344);
        w0 = we_cnt;
        issue("sb", 1'b1, 3'b000, 32'h22, 32'h000000AA, 32'h0, 1'b0, 3);
        drain();
        check("mem_after_sb", mem[8], 32'h11AA3344);
        check("we_pulses_sb", 32'(we_cnt - w0), 32'd1);

        w0 = we_cnt;
        issue("lb", 1'b0, 3'b000, 32'h22, 32'h0, 32'hFFFFFFAA, 1'b0, 2);
        issue("lbu", 1'b0, 3'b100, 32'h22, 32'h0, 32'h000000AA, 1'b0, 2);
        issue("lh", 1'b0, 3'b001, 32'h22, 32'h0, 32'h000011AA, 1'b0, 2);
`ifdef LSU_MISALIGN_TRAP_EN
        issue("lh_misalign", 1'b0, 3'b001, 32'h21, 32'h0, 32'h0, 1'b1, 2);
        issue("lw_misalign", 1'b0, 3'b010, 32'h13, 32'h0, 32'h0, 1'b1, 2);
`else
        issue("lh_misalign", 1'b0, 3'b001, 32'h21, 32'h0, 32'h00003344, 1'b0, 2);
        issue("lw_misalign", 1'b0, 3'b010, 32'h13, 32'h0, 32'hDEADBEEF, 1'b0, 2);
`endif
        drain();
        check("we_pulses_loads", 32'(we_cnt - w0), 32'd0);

        w0 = we_cnt;
        issue("sh", 1'b1, 3'b001, 32'h22, 32'h1234BEEF, 32'h0, 1'b0, 3);
        issue("sbu_illegal", 1'b1, 3'b100, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b1, 2);
        drain();
        check("mem_after_sh", mem[8], 32'hBEEF3344);
        check("we_pulses_sh", 32'(we_cnt - w0), 32'd1);

        issue("lhu", 1'b0, 3'b101, 32'h22, 32'h0, 32'h0000BEEF, 1'b0, 2);
        issue("lh_neg", 1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFFBEEF, 1'b0, 2);
        issue("lb_lane0", 1'b0, 3'b000, 32'h20, 32'h0, 32'h00000044, 1'b0, 2);
        issue("lb_lane3", 1'b0, 3'b000, 32'h23, 32'h0, 32'hFFFFFFBE, 1'b0, 2);
        drain();

        // Illegal funct3 with the core stalling the response for three cycles.
        resp_ready = 1'b0;
        issue("f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 5);
        check("stall_early_valid", 32'(resp_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_valid", 32'(resp_valid), 32'd1);
            check("stall_err", 32'(resp_err), 32'd1);
            check("stall_rdata", resp_rdata, 32'd0);
            check("stall_req_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        drain();

        // Reset while an SB sits in MERGE.
        preload(8'd12, 32'hCAFEF00D);
        issue("sb_rst", 1'b1, 3'b000, 32'h31, 32'h00000055, 32'h0, 1'b0, 3);
        @(negedge clk);
        check("merge_we", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_mem_we", 32'(mem_we), 32'd0);
        check("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mid_req_ready", 32'(req_ready), 32'd1);
        if (sb_q.size() != 0) sb_q.delete(sb_q.size() - 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        check("mem_after_abort", mem[12], 32'hCAFEF00D);

        issue("lw_after_rst", 1'b0, 3'b010, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0, 2);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
